// File: rtl/rotate_right_seq_pkg.sv
// Shared definitions for the staged right shifter/rotator: widths, op codes, FSM states.
package rotate_right_seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned STAGES = 4;

    typedef enum logic [1:0] {
        OP_ROR = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Shift amount applied by log-shifter stage k.
    function automatic logic [CNT_W-1:0] stage_amount(input logic [1:0] k);
        return CNT_W'(1) << k;
    endfunction

endpackage

// File: rtl/rotate_right_seq_ror_stage.sv
// One combinational log-shifter stage: shift/rotate right by a fixed amount when enabled.
module ror_stage
    import rotate_right_seq_pkg::*;
(
    input  logic [DATA_W-1:0] value,
    input  logic [1:0]        op,
    input  logic              enable,
    input  logic [CNT_W-1:0]  amount,
    output logic [DATA_W-1:0] result_c
);

    logic [2*DATA_W-1:0] doubled;
    logic [DATA_W-1:0]   shifted;

    // Rotation takes the low half of the value concatenated with itself;
    // the reserved op code falls into the default and behaves as ROR.
    always_comb begin
        doubled = {value, value} >> amount;
        shifted = doubled[DATA_W-1:0];
        case (op)
            OP_SRL:  shifted = value >> amount;
            OP_SRA:  shifted = DATA_W'($signed(value) >>> amount);
            default: shifted = doubled[DATA_W-1:0];
        endcase
        result_c = enable ? shifted : value;
    end

endmodule

// File: rtl/rotate_right_seq.sv
// Multi-cycle right rotate/shift unit: accept, four log-shifter stages, then hold the result
// on a valid/ready handshake. All outputs come straight from registers.
module rotate_right_seq #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in,
    input  logic [CNT_W-1:0]  bit_cnt,
    input  logic [1:0]        op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] Out,
    output logic              busy
);

    import rotate_right_seq_pkg::*;

    state_e            state_q, state_n;
    logic [1:0]        stage_q, stage_n;
    logic [DATA_W-1:0] work_q, work_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic [1:0]        op_q, op_n;
    logic [DATA_W-1:0] out_q, out_n;
    logic              in_ready_q, in_ready_n;
    logic              out_valid_q, out_valid_n;
    logic              busy_q, busy_n;

    logic [DATA_W-1:0] stage_result_c;

    // A single stage instance, fed the amount for the current stage index.
    ror_stage u_stage (
        .value    (work_q),
        .op       (op_q),
        .enable   (cnt_q[stage_q]),
        .amount   (stage_amount(stage_q)),
        .result_c (stage_result_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            stage_q     <= 2'd0;
            work_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 2'd0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_n;
            stage_q     <= stage_n;
            work_q      <= work_n;
            cnt_q       <= cnt_n;
            op_q        <= op_n;
            out_q       <= out_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
        end
    end

    always_comb begin
        state_n = state_q;
        stage_n = stage_q;
        work_n  = work_q;
        cnt_n   = cnt_q;
        op_n    = op_q;
        out_n   = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    work_n  = in;
                    cnt_n   = bit_cnt;
                    op_n    = op;
                    stage_n = 2'd0;
                    if (bit_cnt == '0) begin
                        out_n   = in;
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RUN;
                    end
                end
            end
            S_RUN: begin
                work_n  = stage_result_c;
                stage_n = stage_q + 2'd1;
                if (stage_q == 2'd3) begin
                    out_n   = stage_result_c;
                    state_n = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        // Status flags are registered copies of the next-state decode.
        in_ready_n  = (state_n == S_IDLE);
        out_valid_n = (state_n == S_DONE);
        busy_n      = (state_n != S_IDLE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign Out       = out_q;

endmodule

// File: tb/tb_rotate_right_seq.sv
// Self-checking bench for rotate_right_seq: vector table, scoreboard, handshake corner cases.
module tb_rotate_right_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic [3:0]  bit_cnt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int n_accept = 0;
    int n_pop    = 0;
    logic [15:0] last_out = 16'h0;
    logic [15:0] sb[$];

    typedef struct {
        logic [1:0]  op;
        logic [15:0] din;
        logic [3:0]  cnt;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    rotate_right_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .bit_cnt   (bit_cnt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Bit-by-bit reference: result bit i comes from source bit i+n.
    function automatic logic [15:0] model(input logic [15:0] d, input logic [1:0] o,
                                          input logic [3:0] c);
        logic [15:0] r;
        int j;
        r = 16'h0;
        for (int i = 0; i < 16; i++) begin
            j = i + int'(c);
            if (j < 16)        r[i] = d[4'(j)];
            else if (o == 2'b01) r[i] = 1'b0;
            else if (o == 2'b10) r[i] = d[15];
            else               r[i] = d[4'(j - 16)];
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Scoreboard: push on accept, pop and compare on output handshake.
    always @(posedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) begin
                sb.push_back(model(din, op, bit_cnt));
                n_accept++;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    timeout("unexpected_output");
                end else begin
                    check("scoreboard", out_data, sb.pop_front());
                    last_out = out_data;
                    n_pop++;
                end
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic [15:0] d, input logic [3:0] c);
        int t;
        t = 0;
        @(negedge clk);
        op = o; din = d; bit_cnt = c; in_valid = 1'b1;
        while (!in_ready && t < 30) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            timeout("send_accept");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
        end
    endtask

    task automatic wait_pop(input int target);
        int t;
        t = 0;
        while (n_pop < target && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (n_pop < target) timeout("wait_output");
    endtask

    initial begin
        int acc0;
        int t;
        vecs[0] = '{2'b00, 16'h0001, 4'd1,  16'h8000};
        vecs[1] = '{2'b00, 16'h1234, 4'd4,  16'h4123};
        vecs[2] = '{2'b00, 16'h1234, 4'd15, 16'h2468};
        vecs[3] = '{2'b01, 16'h8000, 4'd15, 16'h0001};
        vecs[4] = '{2'b10, 16'h8000, 4'd15, 16'hFFFF};
        vecs[5] = '{2'b10, 16'h7F00, 4'd8,  16'h007F};
        vecs[6] = '{2'b11, 16'h0003, 4'd1,  16'h8001};
        vecs[7] = '{2'b01, 16'hF0F0, 4'd3,  16'h1E1E};
        vecs[8] = '{2'b10, 16'h8421, 4'd5,  16'hFC21};

        rst = 1'b1; in_valid = 1'b0; din = 16'h0; bit_cnt = 4'd0; op = 2'b00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 16'(in_ready), 16'h1);
        check("rst_out_valid", 16'(out_valid), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_out", out_data, 16'h0000);
        rst = 1'b0;

        // Latency: out_valid only after the fourth stage edge, then back to IDLE.
        out_ready = 1'b1;
        send(2'b00, 16'h0001, 4'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("lat_valid_%0d", k), 16'(out_valid), (k == 4) ? 16'h1 : 16'h0);
        end
        @(negedge clk);
        check("lat_idle_ready", 16'(in_ready), 16'h1);
        check("lat_idle_valid", 16'(out_valid), 16'h0);
        check("lat_result", last_out, 16'h8000);

        for (int i = 0; i < 9; i++) begin
            acc0 = n_pop;
            send(vecs[i].op, vecs[i].din, vecs[i].cnt);
            wait_pop(acc0 + 1);
            check($sformatf("vec_%0d", i), last_out, vecs[i].exp);
        end

        // Zero count: result straight to DONE, in_ready low until handshake.
        out_ready = 1'b0;
        send(2'b00, 16'hABCD, 4'd0);
        @(negedge clk);
        check("zero_valid", 16'(out_valid), 16'h1);
        check("zero_ready", 16'(in_ready), 16'h0);
        check("zero_out", out_data, 16'hABCD);
        out_ready = 1'b1;
        @(negedge clk);
        check("zero_after_ready", 16'(in_ready), 16'h1);
        check("zero_after_valid", 16'(out_valid), 16'h0);

        // Backpressure in DONE while a new request toggles.
        out_ready = 1'b0;
        send(2'b00, 16'h1234, 4'd4);
        t = 0;
        while (!out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout("bp_wait_valid");
        acc0 = n_accept;
        for (int i = 0; i < 3; i++) begin
            in_valid = (i % 2 == 0); din = 16'h00F0; bit_cnt = 4'd4; op = 2'b00;
            @(negedge clk);
            check($sformatf("bp_out_%0d", i), out_data, 16'h4123);
            check($sformatf("bp_busy_%0d", i), 16'(busy), 16'h1);
            check($sformatf("bp_ready_%0d", i), 16'(in_ready), 16'h0);
        end
        check("bp_no_accept", 16'(n_accept - acc0), 16'h0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 16'(in_ready), 16'h1);
        check("bp_still_no_accept", 16'(n_accept - acc0), 16'h0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check("bp_accept_once", 16'(n_accept - acc0), 16'h1);
        wait_pop(n_pop + 1);
        check("bp_pending_result", last_out, 16'h000F);

        // Reset during stage 2 drops the in-flight operation.
        acc0 = n_pop;
        send(2'b01, 16'hFFFF, 4'd15);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_valid", 16'(out_valid), 16'h0);
        check("mid_rst_out", out_data, 16'h0000);
        check("mid_rst_ready", 16'(in_ready), 16'h1);
        check("mid_rst_busy", 16'(busy), 16'h0);
        repeat (6) @(negedge clk);
        check("mid_rst_no_output", 16'(n_pop - acc0), 16'h0);
        send(2'b00, 16'h00F0, 4'd4);
        wait_pop(acc0 + 1);
        check("post_rst_result", last_out, 16'h000F);

        // Random operations against the reference model.
        for (int i = 0; i < 16; i++) begin
            acc0 = n_pop;
            send(2'($urandom_range(3, 0)), 16'($urandom), 4'($urandom_range(15, 0)));
            wait_pop(acc0 + 1);
        end

        @(negedge clk);
        check("final_sb_empty", 16'(sb.size()), 16'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
